// File: rtl/mem_stage_pkg.sv
// Select encodings shared by the MEM-stage steering muxes.
package mem_stage_pkg;

    localparam logic [3:0] ADDR_SEL_X  = 4'b0001;
    localparam logic [3:0] ADDR_SEL_Y  = 4'b0010;
    localparam logic [3:0] ADDR_SEL_Z  = 4'b0100;
    localparam logic [3:0] ADDR_SEL_SP = 4'b1000;

    localparam logic [2:0] STR_SEL_EXMEM = 3'b001;
    localparam logic [2:0] STR_SEL_MEMWB = 3'b010;
    localparam logic [2:0] STR_SEL_CROSS = 3'b100;

    typedef enum logic [1:0] {
        WB_SEL_EXMEM = 2'b00,
        WB_SEL_LOAD  = 2'b01,
        WB_SEL_SFR   = 2'b10,
        WB_SEL_RSVD  = 2'b11
    } wb_sel_e;

endpackage

// File: rtl/byte_onehot_sel.sv
// Priority one-hot 3:1 byte selector; lowest set select bit wins, none set gives zero.
// Latency: purely combinational.
// Backpressure: none.
module byte_onehot_sel
    import mem_stage_pkg::*;
(
    input  logic [2:0] sel,
    input  logic [7:0] src_exmem,
    input  logic [7:0] src_memwb,
    input  logic [7:0] src_cross,
    output logic [7:0] dat
);

    always_comb begin
        dat = 8'h00;
        if (|(sel & STR_SEL_EXMEM))
            dat = src_exmem;
        else if (|(sel & STR_SEL_MEMWB))
            dat = src_memwb;
        else if (|(sel & STR_SEL_CROSS))
            dat = src_cross;
    end

endmodule

// File: rtl/mem_stage_mux_bank.sv
// MEM-stage data steering: address, store-data and MEM/WB source muxes into output flops.
// Latency: one cycle, every output is registered; captures every cycle.
// Backpressure: none; stalls are handled by the surrounding pipeline registers.
module mem_stage_mux_bank
    import mem_stage_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  addr_sel,
    input  logic [15:0] x_ptr,
    input  logic [15:0] y_ptr,
    input  logic [15:0] z_ptr,
    input  logic [15:0] stack_ptr,
    output logic [15:0] mem_addr,
    input  logic [2:0]  str_sel_top,
    input  logic [2:0]  str_sel_bot,
    input  logic [7:0]  ex_mem_data_top,
    input  logic [7:0]  ex_mem_data_bot,
    input  logic [7:0]  mem_wb_data_top,
    input  logic [7:0]  mem_wb_data_bot,
    output logic [15:0] mem_data,
    input  logic [1:0]  wb_sel,
    input  logic [7:0]  sfr_data,
    input  logic [7:0]  ld_res_top,
    input  logic [7:0]  ld_res_bot,
    output logic [7:0]  mem_data_out_top,
    output logic [7:0]  mem_data_out_bot
);

    logic [15:0] addr_nxt;
    logic [7:0]  str_top_nxt;
    logic [7:0]  str_bot_nxt;
    logic [7:0]  wb_top_nxt;
    logic [7:0]  wb_bot_nxt;

    always_comb begin
        addr_nxt = 16'h0000;
        if (|(addr_sel & ADDR_SEL_X))
            addr_nxt = x_ptr;
        else if (|(addr_sel & ADDR_SEL_Y))
            addr_nxt = y_ptr;
        else if (|(addr_sel & ADDR_SEL_Z))
            addr_nxt = z_ptr;
        else if (|(addr_sel & ADDR_SEL_SP))
            addr_nxt = stack_ptr;
    end

    // Cross-forward lets a store pick up the opposite half of the MEM/WB word.
    byte_onehot_sel u_str_top (
        .sel       (str_sel_top),
        .src_exmem (ex_mem_data_top),
        .src_memwb (mem_wb_data_top),
        .src_cross (mem_wb_data_bot),
        .dat       (str_top_nxt)
    );

    byte_onehot_sel u_str_bot (
        .sel       (str_sel_bot),
        .src_exmem (ex_mem_data_bot),
        .src_memwb (mem_wb_data_bot),
        .src_cross (mem_wb_data_top),
        .dat       (str_bot_nxt)
    );

    always_comb begin
        wb_top_nxt = 8'h00;
        wb_bot_nxt = 8'h00;
        case (wb_sel_e'(wb_sel))
            WB_SEL_EXMEM: begin
                wb_top_nxt = ex_mem_data_top;
                wb_bot_nxt = ex_mem_data_bot;
            end
            WB_SEL_LOAD: begin
                wb_top_nxt = ld_res_top;
                wb_bot_nxt = ld_res_bot;
            end
            WB_SEL_SFR: begin
                wb_bot_nxt = sfr_data;
            end
            default: begin
                wb_top_nxt = 8'h00;
                wb_bot_nxt = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr         <= 16'h0000;
            mem_data         <= 16'h0000;
            mem_data_out_top <= 8'h00;
            mem_data_out_bot <= 8'h00;
        end else begin
            mem_addr         <= addr_nxt;
            mem_data         <= {str_top_nxt, str_bot_nxt};
            mem_data_out_top <= wb_top_nxt;
            mem_data_out_bot <= wb_bot_nxt;
        end
    end

endmodule

// File: tb/tb_mem_stage_mux_bank.sv
// Randomised and directed bench for mem_stage_mux_bank against a priority-select reference model.
module tb_mem_stage_mux_bank;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  addr_sel;
    logic [15:0] x_ptr, y_ptr, z_ptr, stack_ptr;
    logic [15:0] mem_addr;
    logic [2:0]  str_sel_top, str_sel_bot;
    logic [7:0]  ex_mem_data_top, ex_mem_data_bot;
    logic [7:0]  mem_wb_data_top, mem_wb_data_bot;
    logic [15:0] mem_data;
    logic [1:0]  wb_sel;
    logic [7:0]  sfr_data, ld_res_top, ld_res_bot;
    logic [7:0]  mem_data_out_top, mem_data_out_bot;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_addr, exp_data, exp_wb;

    always #5 clock = ~clock;

    mem_stage_mux_bank dut (
        .clock            (clock),
        .reset            (reset),
        .addr_sel         (addr_sel),
        .x_ptr            (x_ptr),
        .y_ptr            (y_ptr),
        .z_ptr            (z_ptr),
        .stack_ptr        (stack_ptr),
        .mem_addr         (mem_addr),
        .str_sel_top      (str_sel_top),
        .str_sel_bot      (str_sel_bot),
        .ex_mem_data_top  (ex_mem_data_top),
        .ex_mem_data_bot  (ex_mem_data_bot),
        .mem_wb_data_top  (mem_wb_data_top),
        .mem_wb_data_bot  (mem_wb_data_bot),
        .mem_data         (mem_data),
        .wb_sel           (wb_sel),
        .sfr_data         (sfr_data),
        .ld_res_top       (ld_res_top),
        .ld_res_bot       (ld_res_bot),
        .mem_data_out_top (mem_data_out_top),
        .mem_data_out_bot (mem_data_out_bot)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: scan sources in select-bit order, first hit wins.
    function automatic logic [15:0] ref_addr(input logic [3:0] s);
        logic [15:0] src [4];
        src[0] = x_ptr; src[1] = y_ptr; src[2] = z_ptr; src[3] = stack_ptr;
        for (int i = 0; i < 4; i++)
            if (s[i]) return src[i];
        return 16'h0000;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [2:0] s, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] c);
        logic [7:0] src [3];
        src[0] = a; src[1] = b; src[2] = c;
        for (int i = 0; i < 3; i++)
            if (s[i]) return src[i];
        return 8'h00;
    endfunction

    function automatic logic [15:0] ref_wb(input logic [1:0] s);
        case (s)
            2'd0:    return {ex_mem_data_top, ex_mem_data_bot};
            2'd1:    return {ld_res_top, ld_res_bot};
            2'd2:    return {8'h00, sfr_data};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_addr"}, mem_addr, exp_addr);
        check({tag, "_data"}, mem_data, exp_data);
        check({tag, "_wb"}, {mem_data_out_top, mem_data_out_bot}, exp_wb);
    endtask

    // Inputs are already driven; outputs must still show the previous capture,
    // then after one edge must show the model's result for these inputs.
    task automatic cycle(input string tag);
        logic [15:0] na, nd, nw;
        na = ref_addr(addr_sel);
        nd = {ref_byte(str_sel_top, ex_mem_data_top, mem_wb_data_top, mem_wb_data_bot),
              ref_byte(str_sel_bot, ex_mem_data_bot, mem_wb_data_bot, mem_wb_data_top)};
        nw = ref_wb(wb_sel);
        check_all({tag, "_hold"});
        @(posedge clock);
        #1;
        exp_addr = na; exp_data = nd; exp_wb = nw;
        check_all(tag);
    endtask

    task automatic randomize_inputs();
        addr_sel        = 4'($urandom);
        x_ptr           = 16'($urandom);
        y_ptr           = 16'($urandom);
        z_ptr           = 16'($urandom);
        stack_ptr       = 16'($urandom);
        str_sel_top     = 3'($urandom);
        str_sel_bot     = 3'($urandom);
        ex_mem_data_top = 8'($urandom);
        ex_mem_data_bot = 8'($urandom);
        mem_wb_data_top = 8'($urandom);
        mem_wb_data_bot = 8'($urandom);
        wb_sel          = 2'($urandom);
        sfr_data        = 8'($urandom);
        ld_res_top      = 8'($urandom);
        ld_res_bot      = 8'($urandom);
    endtask

    task automatic reset_midcycle(input string tag);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        exp_addr = 16'h0; exp_data = 16'h0; exp_wb = 16'h0;
        check_all({tag, "_async"});
        @(posedge clock);
        #1;
        check_all({tag, "_held"});
        randomize_inputs();
        reset = 1'b0;
        #1;
        check_all({tag, "_deassert"});
        cycle({tag, "_first"});
    endtask

    logic [3:0]  addr_tbl [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0110};
    logic [15:0] addr_exp [6] = '{16'h1111, 16'h2222, 16'h3333, 16'hFFF0, 16'h0000, 16'h2222};
    logic [2:0]  str_tbl  [4] = '{3'b001, 3'b010, 3'b100, 3'b000};
    logic [15:0] str_exp  [4] = '{16'hABCD, 16'h1234, 16'h3412, 16'h0000};
    logic [15:0] wb_exp   [4] = '{16'h5AA5, 16'hFF80, 16'h003C, 16'h0000};

    initial begin
        reset = 1'b1;
        addr_sel = '0; x_ptr = '0; y_ptr = '0; z_ptr = '0; stack_ptr = '0;
        str_sel_top = '0; str_sel_bot = '0;
        ex_mem_data_top = '0; ex_mem_data_bot = '0;
        mem_wb_data_top = '0; mem_wb_data_bot = '0;
        wb_sel = '0; sfr_data = '0; ld_res_top = '0; ld_res_bot = '0;
        exp_addr = '0; exp_data = '0; exp_wb = '0;
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Load nonzero state, then hit it with an asynchronous reset.
        randomize_inputs();
        addr_sel = 4'b0001; str_sel_top = 3'b001; str_sel_bot = 3'b001; wb_sel = 2'b00;
        x_ptr = 16'h1357; ex_mem_data_top = 8'h11; ex_mem_data_bot = 8'h22;
        cycle("preload");
        reset_midcycle("rst1");

        x_ptr = 16'h1111; y_ptr = 16'h2222; z_ptr = 16'h3333; stack_ptr = 16'hFFF0;
        for (int i = 0; i < 6; i++) begin
            addr_sel = addr_tbl[i];
            cycle("addr");
            check("addr_table", mem_addr, addr_exp[i]);
        end

        ex_mem_data_top = 8'hAB; ex_mem_data_bot = 8'hCD;
        mem_wb_data_top = 8'h12; mem_wb_data_bot = 8'h34;
        for (int i = 0; i < 4; i++) begin
            str_sel_top = str_tbl[i];
            str_sel_bot = (i == 3) ? 3'b001 : str_tbl[i];
            cycle("store");
            if (i == 3)
                check("store_top_none", {8'h00, mem_data[15:8]}, 16'h0000);
            else
                check("store_table", mem_data, str_exp[i]);
        end

        ex_mem_data_top = 8'h5A; ex_mem_data_bot = 8'hA5;
        ld_res_top = 8'hFF; ld_res_bot = 8'h80; sfr_data = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            wb_sel = 2'(i);
            cycle("wb");
            check("wb_table", {mem_data_out_top, mem_data_out_bot}, wb_exp[i]);
        end

        for (int i = 0; i < 8; i++) begin
            randomize_inputs();
            cycle("b2b");
        end

        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            cycle("rand");
        end

        reset_midcycle("rst2");
        for (int i = 0; i < 20; i++) begin
            randomize_inputs();
            cycle("post_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_mux_bank.md
# mem_stage_mux_bank

Data-steering block of the MEM pipeline stage. It bundles three selectors:
- the data-memory address mux, choosing X/Y/Z/stack pointer;
- the store-data mux, choosing forwarded EX/MEM or MEM/WB bytes per half;
- the MEM/WB input mux, choosing ALU result, load result or SFR read data.

All outputs are registered on `clock`, so the block presents memory address/data and MEM/WB data one cycle after its inputs.

## Interface
- No parameters; all widths are fixed.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset; clears all output registers.
- `addr_sel` in 4: one-hot pointer select, decoded upstream from instruction[19:18].
- `x_ptr`, `y_ptr`, `z_ptr`, `stack_ptr` in 16 each: address sources.
- `mem_addr` out 16: data-memory address (bits [15:0]).
- `str_sel_top`, `str_sel_bot` in 3 each: one-hot store-byte selects.
- `ex_mem_data_top`, `ex_mem_data_bot` in 8 each: EX/MEM data bytes.
- `mem_wb_data_top`, `mem_wb_data_bot` in 8 each: MEM/WB register outputs, used for forwarding.
- `mem_data` out 16: store data, {top, bot}.
- `wb_sel` in 2: MEM/WB source select.
- `sfr_data` in 8: SFR file read data.
- `ld_res_top`, `ld_res_bot` in 8 each: sign-extended load result.
- `mem_data_out_top`, `mem_data_out_bot` out 8 each: bytes to the MEM/WB register.

## Operation
- Address mux:
  - addr_sel[0] selects x_ptr, [1] y_ptr, [2] z_ptr, [3] stack_ptr.
  - The lowest set bit wins.
  - All-zero gives 0x0000.
- Store mux, top byte:
  - bit0 selects ex_mem_data_top, bit1 mem_wb_data_top, bit2 mem_wb_data_bot (cross-forward).
  - The lowest set bit wins; none set gives 0x00.
- Store mux, bottom byte:
  - bit0 selects ex_mem_data_bot, bit1 mem_wb_data_bot, bit2 mem_wb_data_top.
  - Same priority and default as the top byte.
  - mem_data = {top result, bottom result}.
- WB mux:
  - 2'b00: outputs = {ex_mem_data_top, ex_mem_data_bot}.
  - 2'b01: outputs = {ld_res_top, ld_res_bot}.
  - 2'b10: top = 0x00, bot = sfr_data.
  - 2'b11: reserved; both outputs 0x00.
- The three muxes are independent; no cross-coupling between their selects.

## Timing
- Every output is a flop with one-cycle latency: output at edge N+1 reflects inputs sampled at edge N.
- Reset asserted forces mem_addr = 0x0000, mem_data = 0x0000 and both WB bytes = 0x00 immediately, regardless of clock.
- Outputs hold 0 while reset is high.
- First capture occurs at the first rising edge after reset deasserts.
- Reset asserted mid-stream discards in-flight values; there is no recovery state.
- There is no stall or enable: the block captures every cycle. Stall freezing is the responsibility of the pipeline registers.
- No handshake, no FSM.

## Structure
- Shared package `mem_stage_pkg` holds the constants:
  - ADDR_SEL_X/Y/Z/SP (4'b0001…4'b1000);
  - STR_SEL_EXMEM/MEMWB/CROSS (3'b001/010/100);
  - WB_SEL_EXMEM/LOAD/SFR/RSVD.
- One natural sub-module, `byte_onehot_sel`: priority one-hot 3:1 byte selector with zero default. Instantiate it twice for the store halves.
- Address and WB muxes are inline combinational logic ahead of the output flops.

## Test plan
- Reset: drive nonzero inputs and assert reset between edges. All outputs must read 0 before the next edge, and stay 0 until after deassert plus one edge.
- Address: x=0x1111, y=0x2222, z=0x3333, sp=0xFFF0. Stepping addr_sel 0001/0010/0100/1000 must give mem_addr 0x1111/0x2222/0x3333/0xFFF0, each one edge late. addr_sel 0000 → 0x0000; 0110 → 0x2222.
- Store: ex=(0xAB,0xCD), memwb=(0x12,0x34).
  - top=001, bot=001 → 0xABCD.
  - top=010, bot=010 → 0x1234.
  - top=100, bot=100 → 0x3412.
  - top=000 → top byte 0x00.
- WB: ex=(0x5A,0xA5), ld=(0xFF,0x80), sfr=0x3C. wb_sel 00/01/10/11 must give 0x5AA5/0xFF80/0x003C/0x0000.
- Back-to-back: change all selects every cycle for 8 cycles. Each output must match the expected value for the previous cycle's inputs, with no bubbles.
